output_conditioner: RTL
=======================

Name: output_conditioner

Overview:
- Transmit-side counterpart of the input conditioner: takes single-cycle change requests from synchronous logic and drives a clean, rate-limited output bus (LEDs, off-board lines, another clock domain's conditioner input).
- Guarantees a minimum stable time per output value so a downstream debouncer with equal or shorter waittime never drops a change.
- Queues one pending request during the hold window and reports edges and overruns as single-cycle pulses.

Parameters:
- width, 8, output bus width in bits.
- holdtime, 3, minimum number of clock cycles each driven value is held (>=1).
- counterwidth, 3, hold counter width in bits, >= log2(holdtime+1).

Ports:
- clk  input  1  clock; all logic on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- request  input  1  single-cycle request strobe.
- requestdata  input  width  value to drive; sampled only when request=1.
- driven  output  width  registered output bus.
- busy  output  1  high while in the hold window.
- changed  output  1  1-cycle pulse on any bit change of driven.
- positiveedge  output  1  1-cycle pulse when driven[0] goes 0->1.
- negativeedge  output  1  1-cycle pulse when driven[0] goes 1->0.
- overrun  output  1  1-cycle pulse when a pending request is overwritten.

Behaviour:
- Reset (reset_n=0, async): driven=0, busy=0, changed=0, positiveedge=0, negativeedge=0, overrun=0, pending cleared, counter=0, state=IDLE. Reset asserted mid-hold discards the pending value; driven returns to 0 immediately.
- All outputs are registered; pulse outputs are 0 on every cycle not specified below.
- States: IDLE, HOLD.
- IDLE, request=1, requestdata!=driven: at edge E, driven<=requestdata; changed=1 and edge pulses per bit 0 for the cycle after E; counter<=1; busy<=1; go to HOLD.
- IDLE, request=1, requestdata==driven: no change, no pulses, remain in IDLE.
- HOLD: counter increments each edge. A request stores requestdata in the pending register and sets pendingvalid. If pendingvalid is already set, the pending register is overwritten (latest wins) and overrun pulses for one cycle.
- End of hold, at the edge where counter==holdtime:
  - The candidate is requestdata if request=1 on that cycle (highest priority, no overrun); otherwise the pending value if pendingvalid; otherwise none.
  - If a candidate exists and differs from driven: apply it as in IDLE (changed and edge pulses, counter<=1), clear pending, stay in HOLD.
  - Otherwise: clear pending, busy<=0, go to IDLE.
- Net timing: consecutive changes of driven are at least holdtime edges apart. With holdtime=3, changes at edge E and E+3 give driven stable for exactly 3 cycles. busy is high for those holdtime cycles and stays high across back-to-back applications.
- Latency: a request in IDLE appears on driven one edge later.
- A request equal to the value already pending is still stored. It does not pulse overrun unless pendingvalid was already set.
- holdtime=1: HOLD lasts one cycle and requests on every cycle are applied on every edge.

Test Plan:
- Reset: hold reset_n=0 with request=1, requestdata=8'hFF -> driven=0, all pulses 0. Release, request 8'h01 -> driven=8'h01 next cycle; changed=1 and positiveedge=1 for one cycle; busy=1 for 3 cycles.
- Same value: driven=8'h01 in IDLE, request 8'h01 -> no changed pulse, busy stays 0.
- Queued: request 8'h01 at cycle 0, then 8'h00 at cycle 1 -> driven=01 at cycle 1, 00 at cycle 4; negativeedge at cycle 4; busy continuous over cycles 1-6.
- Overrun: during hold, request 8'h02 then 8'h04 -> overrun pulses once; only 8'h04 is driven, at the hold-end edge.
- Hold-end collision: pending=8'h02 with request 8'h08 on the hold-end cycle -> driven=8'h08, no overrun, 8'h02 never driven.
- Async reset mid-hold with pendingvalid set -> driven=0 immediately; after release no change is applied until a new request.

Source files
------------

// File: rtl/output_conditioner.sv
// Rate-limited output driver: applies single-cycle change requests to a registered bus,
// holding each value for at least holdtime cycles and queueing one pending request.
module output_conditioner #(
    parameter int width        = 8,
    parameter int holdtime     = 3,
    parameter int counterwidth = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             request,
    input  logic [width-1:0] requestdata,
    output logic [width-1:0] driven,
    output logic             busy,
    output logic             changed,
    output logic             positiveedge,
    output logic             negativeedge,
    output logic             overrun
);

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [counterwidth-1:0] hold_count = counterwidth'(holdtime);
    localparam logic [counterwidth-1:0] count_one  = counterwidth'(1);

    state_t                  state_reg, state_next;
    logic [counterwidth-1:0] counter_reg, counter_next;
    logic [width-1:0]        driven_reg, driven_next;
    logic [width-1:0]        pending_reg, pending_next;
    logic                    pending_valid_reg, pending_valid_next;
    logic                    busy_reg, busy_next;
    logic                    changed_reg, changed_next;
    logic                    pos_reg, pos_next;
    logic                    neg_reg, neg_next;
    logic                    overrun_reg, overrun_next;

    logic                    apply;
    logic                    has_candidate;
    logic [width-1:0]        candidate;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg         <= IDLE;
            counter_reg       <= '0;
            driven_reg        <= '0;
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
            busy_reg          <= 1'b0;
            changed_reg       <= 1'b0;
            pos_reg           <= 1'b0;
            neg_reg           <= 1'b0;
            overrun_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            counter_reg       <= counter_next;
            driven_reg        <= driven_next;
            pending_reg       <= pending_next;
            pending_valid_reg <= pending_valid_next;
            busy_reg          <= busy_next;
            changed_reg       <= changed_next;
            pos_reg           <= pos_next;
            neg_reg           <= neg_next;
            overrun_reg       <= overrun_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next         = state_reg;
        counter_next       = counter_reg;
        driven_next        = driven_reg;
        pending_next       = pending_reg;
        pending_valid_next = pending_valid_reg;
        busy_next          = busy_reg;
        changed_next       = 1'b0;
        pos_next           = 1'b0;
        neg_next           = 1'b0;
        overrun_next       = 1'b0;
        apply              = 1'b0;
        has_candidate      = 1'b0;
        candidate          = requestdata;

        case (state_reg)
            IDLE: begin
                apply = request && (requestdata != driven_reg);
            end
            HOLD: begin
                if (counter_reg == hold_count) begin
                    // A live request on the hold-end cycle beats the queued value.
                    if (request) begin
                        has_candidate = 1'b1;
                        candidate     = requestdata;
                    end else if (pending_valid_reg) begin
                        has_candidate = 1'b1;
                        candidate     = pending_reg;
                    end
                    pending_valid_next = 1'b0;
                    if (has_candidate && (candidate != driven_reg)) begin
                        apply = 1'b1;
                    end else begin
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end
                end else begin
                    counter_next = counter_reg + count_one;
                    if (request) begin
                        pending_next       = requestdata;
                        pending_valid_next = 1'b1;
                        overrun_next       = pending_valid_reg;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        if (apply) begin
            driven_next  = candidate;
            changed_next = 1'b1;
            pos_next     = !driven_reg[0] && candidate[0];
            neg_next     = driven_reg[0] && !candidate[0];
            counter_next = count_one;
            busy_next    = 1'b1;
            state_next   = HOLD;
        end
    end

    // Output logic
    always_comb begin
        driven       = driven_reg;
        busy         = busy_reg;
        changed      = changed_reg;
        positiveedge = pos_reg;
        negativeedge = neg_reg;
        overrun      = overrun_reg;
    end

endmodule
